// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the read slave and the planned write slave:
// burst encodings, response codes, default channel widths, the FSM state
// type of the read slave, and a helper that recognises legal WRAP lengths.
// Kept next to define.sv, which carries the project-wide build macros.
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 8;
    localparam int AXI_SIZE_BITS = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } rd_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [31:0] len);
        case (len)
            32'd1, 32'd3, 32'd7, 32'd15: wrap_len_legal = 1'b1;
            default:                     wrap_len_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational next-beat address for an AXI burst. Shared between the read
// slave and the planned write slave.
//   addr      in  current beat byte address
//   size      in  log2 bytes per beat
//   len       in  beats minus one
//   burst     in  raw burst encoding (11 and illegal WRAP lengths act as INCR)
//   next_addr out address of the following beat
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS,
    parameter int SIZE_BITS = AXI_SIZE_BITS
) (
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [SIZE_BITS-1:0] size,
    input  logic [LEN_BITS-1:0]  len,
    input  logic [1:0]           burst,
    output logic [ADDR_BITS-1:0] next_addr
);

    logic [ADDR_BITS-1:0] step_s;
    logic [ADDR_BITS-1:0] container_s;
    logic [ADDR_BITS-1:0] wrap_mask_s;
    logic [ADDR_BITS-1:0] incr_s;

    assign step_s      = ADDR_BITS'(1) << size;
    assign container_s = ({{(ADDR_BITS-LEN_BITS){1'b0}}, len} + ADDR_BITS'(1)) << size;
    assign wrap_mask_s = container_s - ADDR_BITS'(1);
    assign incr_s      = addr + step_s;

    // Select the next address by burst type; the upper address bits stay
    // inside the wrap container, only the low bits advance and wrap.
    always_comb begin
        next_addr = incr_s;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                if (wrap_len_legal(32'(len))) begin
                    next_addr = (addr & ~wrap_mask_s) | (incr_s & wrap_mask_s);
                end else begin
                    next_addr = incr_s;
                end
            end
            default:     next_addr = incr_s;
        endcase
    end

endmodule

// File: rtl/axi_slave_rd.sv
// ---------------------------------------------------------------------------
// axi_slave_rd
// AXI read-channel slave returning R beats from an internal word memory.
// FIXED / INCR / WRAP bursts; DECERR for out-of-range words, SLVERR for
// oversize beats, reserved burst type or illegal WRAP length.
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   ar_valid/ar_ready/ar_addr/ar_len/ar_size/ar_burst/ar_cache  AR channel
//   r_valid/r_ready/r_data/r_last/r_resp                          R channel
//   mem_we/mem_waddr/mem_wdata   backdoor preload write port
//   rd_wait                      wait states before each beat
//                                (only with AXI_SLAVE_RD_WAIT_EN defined)
// ar_cache is accepted and has no effect.
// ---------------------------------------------------------------------------
module axi_slave_rd
    import axi_pkg::*;
#(
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS,
    parameter int SIZE_BITS = AXI_SIZE_BITS,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    input  logic [ADDR_BITS-1:0]         ar_addr,
    input  logic [LEN_BITS-1:0]          ar_len,
    input  logic [SIZE_BITS-1:0]         ar_size,
    input  logic [1:0]                   ar_burst,
    input  logic [3:0]                   ar_cache,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [DATA_BITS-1:0]         r_data,
    output logic                         r_last,
    output logic [1:0]                   r_resp,
`ifdef AXI_SLAVE_RD_WAIT_EN
    input  logic [3:0]                   rd_wait,
`endif
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_BITS-1:0]         mem_wdata
);

    localparam int                   OFF_BITS    = $clog2(DATA_BITS / 8);
    localparam int                   IDX_BITS    = $clog2(MEM_DEPTH);
    localparam logic [SIZE_BITS-1:0] SIZE_MAX    = SIZE_BITS'(OFF_BITS);
    localparam logic [ADDR_BITS-1:0] DEPTH_WORDS = ADDR_BITS'(MEM_DEPTH);

    logic [DATA_BITS-1:0] mem [MEM_DEPTH];

    rd_state_e            state_r,    state_nxt;
    logic [ADDR_BITS-1:0] addr_r,     addr_nxt;
    logic [LEN_BITS-1:0]  len_r,      len_nxt;
    logic [SIZE_BITS-1:0] size_r,     size_nxt;
    logic [1:0]           burst_r,    burst_nxt;
    logic [LEN_BITS-1:0]  cnt_r,      cnt_nxt;
    logic                 slverr_r,   slverr_nxt;
    logic                 ar_ready_r, ar_ready_nxt;
    logic                 r_valid_r,  r_valid_nxt;
    logic [DATA_BITS-1:0] r_data_r,   r_data_nxt;
    logic                 r_last_r,   r_last_nxt;
    logic [1:0]           r_resp_r,   r_resp_nxt;
`ifdef AXI_SLAVE_RD_WAIT_EN
    logic [3:0]           wait_r,     wait_nxt;
`endif

    // Beat load port: one address is presented to the memory per cycle.
    logic                 load_s;
    logic [ADDR_BITS-1:0] load_addr_s;
    logic [LEN_BITS-1:0]  load_cnt_s;
    logic [LEN_BITS-1:0]  load_len_s;
    logic                 load_err_s;
    logic [ADDR_BITS-1:0] widx_s;
    logic                 decerr_s;
    logic [DATA_BITS-1:0] rd_word_s;

    logic                 ar_hs_s;
    logic                 r_hs_s;
    logic                 in_slverr_s;
    logic [ADDR_BITS-1:0] gen_next_s;

    assign ar_hs_s = ar_valid && ar_ready_r;
    assign r_hs_s  = r_valid_r && r_ready;

    // SLVERR is a property of the whole request, so it is judged once at AR.
    assign in_slverr_s = (ar_size > SIZE_MAX) ||
                         (ar_burst == 2'b11) ||
                         ((ar_burst == BURST_WRAP) && !wrap_len_legal(32'(ar_len)));

    assign widx_s    = load_addr_s >> OFF_BITS;
    assign decerr_s  = (widx_s >= DEPTH_WORDS);
    assign rd_word_s = mem[widx_s[IDX_BITS-1:0]];

    axi_burst_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .LEN_BITS  (LEN_BITS),
        .SIZE_BITS (SIZE_BITS)
    ) u_addr_gen (
        .addr      (addr_r),
        .size      (size_r),
        .len       (len_r),
        .burst     (burst_r),
        .next_addr (gen_next_s)
    );

    // Backdoor preload; the memory itself is never reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state and next-output logic of the read FSM.
    always_comb begin
        state_nxt    = state_r;
        addr_nxt     = addr_r;
        len_nxt      = len_r;
        size_nxt     = size_r;
        burst_nxt    = burst_r;
        cnt_nxt      = cnt_r;
        slverr_nxt   = slverr_r;
        ar_ready_nxt = ar_ready_r;
        r_valid_nxt  = r_valid_r;
        r_data_nxt   = r_data_r;
        r_last_nxt   = r_last_r;
        r_resp_nxt   = r_resp_r;
`ifdef AXI_SLAVE_RD_WAIT_EN
        wait_nxt     = wait_r;
`endif
        load_s       = 1'b0;
        load_addr_s  = addr_r;
        load_cnt_s   = cnt_r;
        load_len_s   = len_r;
        load_err_s   = slverr_r;

        case (state_r)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    state_nxt    = ST_DATA;
                    ar_ready_nxt = 1'b0;
                    addr_nxt     = ar_addr;
                    len_nxt      = ar_len;
                    size_nxt     = ar_size;
                    burst_nxt    = ar_burst;
                    cnt_nxt      = '0;
                    slverr_nxt   = in_slverr_s;
                    load_addr_s  = ar_addr;
                    load_cnt_s   = '0;
                    load_len_s   = ar_len;
                    load_err_s   = in_slverr_s;
`ifdef AXI_SLAVE_RD_WAIT_EN
                    wait_nxt = rd_wait;
                    if (rd_wait == 4'd0) begin
                        load_s = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
`else
                    load_s = 1'b1;
`endif
                end else begin
                    ar_ready_nxt = 1'b1;
                end
            end

            ST_DATA: begin
                if (r_hs_s) begin
                    if (r_last_r) begin
                        state_nxt    = ST_IDLE;
                        r_valid_nxt  = 1'b0;
                        r_last_nxt   = 1'b0;
                        ar_ready_nxt = 1'b1;
                    end else begin
                        // Advance now; the beat is loaded immediately or
                        // once the wait counter expires, from addr_r/cnt_r.
                        addr_nxt    = gen_next_s;
                        cnt_nxt     = cnt_r + LEN_BITS'(1);
                        load_addr_s = gen_next_s;
                        load_cnt_s  = cnt_r + LEN_BITS'(1);
                        r_valid_nxt = 1'b0;
`ifdef AXI_SLAVE_RD_WAIT_EN
                        wait_nxt = rd_wait;
                        if (rd_wait == 4'd0) begin
                            load_s = 1'b1;
                        end else begin
                            load_s = 1'b0;
                        end
`else
                        load_s = 1'b1;
`endif
                    end
                end else if (!r_valid_r) begin
`ifdef AXI_SLAVE_RD_WAIT_EN
                    if (wait_r <= 4'd1) begin
                        wait_nxt = 4'd0;
                        load_s   = 1'b1;
                    end else begin
                        wait_nxt = wait_r - 4'd1;
                        load_s   = 1'b0;
                    end
`else
                    // Unreachable without wait states; reload to recover.
                    load_s = 1'b1;
`endif
                end else begin
                    // Stalled beat: outputs hold their registered values.
                    load_s = 1'b0;
                end
            end

            default: begin
                state_nxt    = ST_IDLE;
                ar_ready_nxt = 1'b0;
                r_valid_nxt  = 1'b0;
                r_last_nxt   = 1'b0;
            end
        endcase

        if (load_s) begin
            r_valid_nxt = 1'b1;
            r_last_nxt  = (load_cnt_s == load_len_s);
            if (decerr_s) begin
                r_data_nxt = '0;
                r_resp_nxt = RESP_DECERR;
            end else begin
                r_data_nxt = rd_word_s;
                r_resp_nxt = load_err_s ? RESP_SLVERR : RESP_OKAY;
            end
        end else begin
            r_valid_nxt = r_valid_nxt;
        end
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            len_r      <= '0;
            size_r     <= '0;
            burst_r    <= 2'b00;
            cnt_r      <= '0;
            slverr_r   <= 1'b0;
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
            r_data_r   <= '0;
            r_last_r   <= 1'b0;
            r_resp_r   <= RESP_OKAY;
`ifdef AXI_SLAVE_RD_WAIT_EN
            wait_r     <= 4'd0;
`endif
        end else begin
            state_r    <= state_nxt;
            addr_r     <= addr_nxt;
            len_r      <= len_nxt;
            size_r     <= size_nxt;
            burst_r    <= burst_nxt;
            cnt_r      <= cnt_nxt;
            slverr_r   <= slverr_nxt;
            ar_ready_r <= ar_ready_nxt;
            r_valid_r  <= r_valid_nxt;
            r_data_r   <= r_data_nxt;
            r_last_r   <= r_last_nxt;
            r_resp_r   <= r_resp_nxt;
`ifdef AXI_SLAVE_RD_WAIT_EN
            wait_r     <= wait_nxt;
`endif
        end
    end

    assign ar_ready = ar_ready_r;
    assign r_valid  = r_valid_r;
    assign r_data   = r_data_r;
    assign r_last   = r_last_r;
    assign r_resp   = r_resp_r;

endmodule

// File: tb/tb_axi_slave_rd.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_rd
// Directed bench for axi_slave_rd: a table of bursts with hand-computed beat
// data/responses, plus hand-written sequences for backdoor-write ordering,
// reset mid-burst and (with AXI_SLAVE_RD_WAIT_EN) wait states.
// ---------------------------------------------------------------------------
module tb_axi_slave_rd;

    logic        aclk = 1'b0;
    logic        areset;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_cache;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic        r_last;
    logic [1:0]  r_resp;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
`ifdef AXI_SLAVE_RD_WAIT_EN
    logic [3:0]  rd_wait;
`endif

    always #5 aclk = ~aclk;

    axi_slave_rd dut (
        .aclk      (aclk),
        .areset    (areset),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .ar_cache  (ar_cache),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_last    (r_last),
        .r_resp    (r_resp),
`ifdef AXI_SLAVE_RD_WAIT_EN
        .rd_wait   (rd_wait),
`endif
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  rdy;    // r_ready pattern, bit (cycle % 4)
    } vec_t;

    localparam int NV = 13;
    vec_t        vec   [NV];
    logic [31:0] exp_d [NV][8];
    logic [1:0]  exp_r [NV][8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mem_write(input int idx, input logic [31:0] d);
        @(negedge aclk);
        mem_we    = 1'b1;
        mem_waddr = 8'(idx);
        mem_wdata = d;
        @(negedge aclk);
        mem_we    = 1'b0;
    endtask

    // Presents an AR and returns at the first negedge after the handshake.
    task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        int t;
        @(negedge aclk);
        ar_addr  = a;
        ar_len   = l;
        ar_size  = s;
        ar_burst = b;
        ar_valid = 1'b1;
        t = 0;
        while (ar_ready !== 1'b1 && t < 20) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL ar_ready timeout: got 0x%0h, expected 0x1", ar_ready);
        end
        @(negedge aclk);
        ar_valid = 1'b0;
        chk("ar_ready low after accept", 32'(ar_ready), 32'h0);
    endtask

    task automatic run_vec(input int i);
        int beat;
        int cyc;
        send_ar(vec[i].addr, vec[i].len, vec[i].size, vec[i].burst);
        chk($sformatf("v%0d first beat latency", i), 32'(r_valid), 32'h1);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(vec[i].len) && cyc < 200) begin
            r_ready = vec[i].rdy[cyc % 4];
            if (r_valid) begin
                chk($sformatf("v%0d beat%0d data", i, beat), r_data, exp_d[i][beat]);
                chk($sformatf("v%0d beat%0d resp", i, beat), 32'(r_resp), 32'(exp_r[i][beat]));
                chk($sformatf("v%0d beat%0d last", i, beat), 32'(r_last),
                    32'(beat == int'(vec[i].len)));
                if (r_ready) beat++;
            end
            @(negedge aclk);
            cyc++;
        end
        if (beat <= int'(vec[i].len)) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d beat timeout: got %0d beats, expected %0d", i, beat, vec[i].len + 8'd1);
        end
        r_ready = 1'b0;
        chk($sformatf("v%0d r_valid after last", i), 32'(r_valid), 32'h0);
        chk($sformatf("v%0d ar_ready after last", i), 32'(ar_ready), 32'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        areset    = 1'b1;
        ar_valid  = 1'b0;
        ar_addr   = 32'h0;
        ar_len    = 8'h0;
        ar_size   = 3'd2;
        ar_burst  = 2'b01;
        ar_cache  = 4'h3;
        r_ready   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = 8'h0;
        mem_wdata = 32'h0;
`ifdef AXI_SLAVE_RD_WAIT_EN
        rd_wait   = 4'd0;
`endif

        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < 8; j++) begin
                exp_d[i][j] = 32'h0;
                exp_r[i][j] = 2'b00;
            end
        end
        //            addr          len    size  burst  rdy
        vec[0]  = '{32'h0000_0000, 8'd3, 3'd2, 2'b01, 4'b1111};
        exp_d[0][0:3] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        vec[1]  = '{32'h0000_0008, 8'd2, 3'd2, 2'b00, 4'b1111};
        exp_d[1][0:2] = '{32'hA2, 32'hA2, 32'hA2};
        vec[2]  = '{32'h0000_0008, 8'd3, 3'd2, 2'b10, 4'b1111};
        exp_d[2][0:3] = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
        vec[3]  = '{32'h0000_0000, 8'd3, 3'd2, 2'b01, 4'b1001};
        exp_d[3][0:3] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        vec[4]  = '{32'h0000_0400, 8'd0, 3'd2, 2'b01, 4'b1111};
        exp_r[4][0] = 2'b11;
        vec[5]  = '{32'h0000_0000, 8'd1, 3'd3, 2'b01, 4'b1111};
        exp_d[5][0:1] = '{32'hA0, 32'hA2};
        exp_r[5][0:1] = '{2'b10, 2'b10};
        vec[6]  = '{32'h0000_0000, 8'd1, 3'd2, 2'b11, 4'b1111};
        exp_d[6][0:1] = '{32'hA0, 32'hA1};
        exp_r[6][0:1] = '{2'b10, 2'b10};
        vec[7]  = '{32'h0000_0004, 8'd2, 3'd2, 2'b10, 4'b1111};
        exp_d[7][0:2] = '{32'hA1, 32'hA2, 32'hA3};
        exp_r[7][0:2] = '{2'b10, 2'b10, 2'b10};
        vec[8]  = '{32'h0000_03FC, 8'd1, 3'd2, 2'b01, 4'b1111};
        exp_d[8][0:1] = '{32'h55, 32'h0};
        exp_r[8][0:1] = '{2'b00, 2'b11};
        vec[9]  = '{32'h0000_0004, 8'd1, 3'd2, 2'b10, 4'b1111};
        exp_d[9][0:1] = '{32'hA1, 32'hA0};
        vec[10] = '{32'h0000_001C, 8'd7, 3'd2, 2'b10, 4'b1111};
        exp_d[10] = '{32'hA7, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6};
        vec[11] = '{32'h0000_0001, 8'd1, 3'd0, 2'b01, 4'b1111};
        exp_d[11][0:1] = '{32'hA0, 32'hA0};
        vec[12] = '{32'h0000_0400, 8'd0, 3'd3, 2'b01, 4'b1111};
        exp_r[12][0] = 2'b11;

        // Reset values
        #12;
        chk("reset ar_ready", 32'(ar_ready), 32'h0);
        chk("reset r_valid", 32'(r_valid), 32'h0);
        chk("reset r_data", r_data, 32'h0);
        chk("reset r_last", 32'(r_last), 32'h0);
        chk("reset r_resp", 32'(r_resp), 32'h0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("ar_ready before first edge", 32'(ar_ready), 32'h0);
        @(negedge aclk);
        chk("ar_ready first edge after reset", 32'(ar_ready), 32'h1);

        for (int k = 0; k < 8; k++) mem_write(k, 32'hA0 + 32'(k));
        mem_write(255, 32'h55);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backdoor writes during a stalled beat
        send_ar(32'h0, 8'd1, 3'd2, 2'b01);
        chk("bd beat0 data", r_data, 32'hA0);
        mem_we = 1'b1; mem_waddr = 8'd0; mem_wdata = 32'hBB;
        @(negedge aclk);
        mem_waddr = 8'd1; mem_wdata = 32'hB1;
        chk("bd beat0 held after write", r_data, 32'hA0);
        @(negedge aclk);
        mem_we = 1'b0;
        chk("bd beat0 still held", r_data, 32'hA0);
        r_ready = 1'b1;
        @(negedge aclk);
        chk("bd beat1 new data", r_data, 32'hB1);
        chk("bd beat1 last", 32'(r_last), 32'h1);
        @(negedge aclk);
        r_ready = 1'b0;
        chk("bd r_valid after last", 32'(r_valid), 32'h0);
        mem_write(0, 32'hA0);
        mem_write(1, 32'hA1);

        // Reset in the middle of a len=7 burst
        send_ar(32'h0, 8'd7, 3'd2, 2'b01);
        r_ready = 1'b1;
        chk("rst beat0 data", r_data, 32'hA0);
        @(negedge aclk);
        chk("rst beat1 data", r_data, 32'hA1);
        @(negedge aclk);
        chk("rst beat2 data", r_data, 32'hA2);
        areset = 1'b1;
        #1;
        chk("mid reset r_valid", 32'(r_valid), 32'h0);
        chk("mid reset ar_ready", 32'(ar_ready), 32'h0);
        chk("mid reset r_last", 32'(r_last), 32'h0);
        r_ready = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("ar_ready at release", 32'(ar_ready), 32'h0);
        @(negedge aclk);
        chk("ar_ready after release", 32'(ar_ready), 32'h1);
        chk("r_valid after release", 32'(r_valid), 32'h0);
        run_vec(0);

`ifdef AXI_SLAVE_RD_WAIT_EN
        // Two wait states before each beat
        rd_wait = 4'd2;
        send_ar(32'h0, 8'd1, 3'd2, 2'b01);
        chk("wait b0 idle1", 32'(r_valid), 32'h0);
        @(negedge aclk);
        chk("wait b0 idle2", 32'(r_valid), 32'h0);
        @(negedge aclk);
        chk("wait b0 valid", 32'(r_valid), 32'h1);
        chk("wait b0 data", r_data, 32'hA0);
        r_ready = 1'b1;
        @(negedge aclk);
        chk("wait b1 idle1", 32'(r_valid), 32'h0);
        @(negedge aclk);
        chk("wait b1 idle2", 32'(r_valid), 32'h0);
        @(negedge aclk);
        chk("wait b1 valid", 32'(r_valid), 32'h1);
        chk("wait b1 data", r_data, 32'hA1);
        chk("wait b1 last", 32'(r_last), 32'h1);
        @(negedge aclk);
        r_ready = 1'b0;
        chk("wait ar_ready after last", 32'(ar_ready), 32'h1);
        rd_wait = 4'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
